// File: rtl/snake_dir_controller_if.sv
// Button/pause inputs and dir/shift/steps/state outputs of snake_dir_controller.
// master drives the buttons; slave is the controller.
interface snake_dir_controller_if;
  logic       btn_up;
  logic       btn_right;
  logic       btn_down;
  logic       btn_left;
  logic       pause;
  logic [2:0] dir;
  logic       shift;
  logic [7:0] steps;
  logic [1:0] state;

  modport master (
    output btn_up, btn_right, btn_down, btn_left, pause,
    input  dir, shift, steps, state
  );

  modport slave (
    input  btn_up, btn_right, btn_down, btn_left, pause,
    output dir, shift, steps, state
  );
endinterface

// File: rtl/snake_dir_controller.sv
// Direction/step front end for move_register: synchronises buttons, applies the snake rules,
// issues a shift strobe every TICK_DIV cycles. Define SNAKE_DIR_DEBOUNCE_EN for button debouncing.
module snake_dir_controller #(
  parameter int TICK_DIV        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input logic                   clk,
  input logic                   reset,
  snake_dir_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("snake_dir_controller: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  state_t        state_q, state_next;
  logic [3:0]    raw, sync1, sync2, level, level_d, req;
  logic          req_valid;
  logic [1:0]    req_dir;
  logic          reversal;
  logic [CW-1:0] cnt_q, cnt_next;
  logic [1:0]    dir_q, pend_q;
  logic          shift_q, step_fire, pend_load;
  logic [7:0]    steps_q;

  // Bit index equals the direction code (0 up, 1 right, 2 down, 3 left).
  assign raw = {bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
    end
  end

`ifdef SNAKE_DIR_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt [4];

  // Any sample agreeing with the accepted level restarts the run of disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  assign req = level & ~level_d;

  always_comb begin
    req_valid = |req;
    req_dir   = 2'd0;
    if (req[0])      req_dir = 2'd0;
    else if (req[1]) req_dir = 2'd1;
    else if (req[2]) req_dir = 2'd2;
    else if (req[3]) req_dir = 2'd3;
  end

  // Reversal is judged against the committed direction, not the pending one.
  assign reversal = (req_dir == 2'(dir_q + 2'd2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_next = RUN;
      RUN:     if (bus.pause)  state_next = PAUSED;
      PAUSED:  if (!bus.pause) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Pause seen in RUN freezes the counter at once, so a terminal count is held, not lost.
  always_comb begin
    step_fire = 1'b0;
    pend_load = 1'b0;
    cnt_next  = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_next  = '0;
        pend_load = req_valid;
      end
      RUN: begin
        pend_load = req_valid && !reversal;
        if (!bus.pause) begin
          if (cnt_q == TICK_LAST) begin
            step_fire = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt_q + 1'b1;
          end
        end
      end
      PAUSED:  pend_load = req_valid && !reversal;
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      pend_q  <= 2'd1;
      dir_q   <= 2'd1;
      shift_q <= 1'b0;
      steps_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_next;
      shift_q <= step_fire;
      if (pend_load) pend_q <= req_dir;
      if (step_fire) begin
        dir_q   <= pend_q;
        steps_q <= steps_q + 8'd1;
      end
    end
  end

  assign bus.dir   = {1'b0, dir_q};
  assign bus.shift = shift_q;
  assign bus.steps = steps_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_snake_dir_controller.sv
// Randomised and directed bench for snake_dir_controller against a cycle-level reference model.
// Follows SNAKE_DIR_DEBOUNCE_EN to match the build under test.
module tb_snake_dir_controller;
  localparam int TD = 8;
  localparam int DB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  snake_dir_controller_if ifc ();

  snake_dir_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: raw button history and the rules of the game, one update per clock.
  bit hist [4][$];
  bit m_acc [4];
  bit m_acc_prev [4];
  int m_dir, m_pend, m_cnt, m_steps, m_state;
  bit m_shift;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      for (int j = 0; j < DB + 2; j++) hist[i].push_back(1'b0);
      m_acc[i]      = 1'b0;
      m_acc_prev[i] = 1'b0;
    end
    m_dir = 1; m_pend = 1; m_cnt = 0; m_steps = 0; m_state = 0; m_shift = 1'b0;
  endtask

  task automatic model_step();
    bit b [4];
    bit rq [4];
    int rdir, old_state, old_dir, old_pend;
    bit fire, all_diff;
    b[0] = ifc.btn_up; b[1] = ifc.btn_right; b[2] = ifc.btn_down; b[3] = ifc.btn_left;
    rdir = -1;
    fire = 1'b0;
    for (int i = 0; i < 4; i++) rq[i] = m_acc[i] && !m_acc_prev[i];
    for (int i = 3; i >= 0; i--) if (rq[i]) rdir = i;
    for (int i = 0; i < 4; i++) begin
      hist[i].push_front(b[i]);
      void'(hist[i].pop_back());
      m_acc_prev[i] = m_acc[i];
`ifdef SNAKE_DIR_DEBOUNCE_EN
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[i][j] == m_acc[i]) all_diff = 1'b0;
      if (all_diff) m_acc[i] = !m_acc[i];
`else
      all_diff = 1'b0;
      m_acc[i] = hist[i][1];
`endif
    end
    old_state = m_state; old_dir = m_dir; old_pend = m_pend;
    case (old_state)
      0: if (rdir >= 0) begin m_pend = rdir; m_cnt = 0; m_state = 1; end
      1: begin
        if (ifc.pause) m_state = 2;
        else if (m_cnt == TD - 1) begin m_cnt = 0; fire = 1'b1; end
        else m_cnt++;
      end
      default: if (!ifc.pause) m_state = 1;
    endcase
    if (old_state != 0 && rdir >= 0 && rdir != (old_dir + 2) % 4) m_pend = rdir;
    if (fire) begin
      m_dir   = old_pend;
      m_steps = (m_steps + 1) % 256;
    end
    m_shift = fire;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic set_btns(input bit [3:0] v);
    ifc.btn_up = v[0]; ifc.btn_right = v[1]; ifc.btn_down = v[2]; ifc.btn_left = v[3];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_btns(4'b0000);
    ifc.pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Press, hold 10 cycles, release and let at least two full steps go by.
  task automatic press_settle(input bit [3:0] v);
    set_btns(v);
    repeat (10) @(negedge clk);
    set_btns(4'b0000);
    repeat (18) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_total++;
      if (ifc.dir !== 3'd1 || ifc.shift !== 1'b0 || ifc.steps !== 8'd0 || ifc.state !== 2'd0)
        $display("FAIL reset_idle c=%0d: dir/shift/steps/state got %0d/%0d/%0d/%0d expected 1/0/0/0",
                 c, ifc.dir, ifc.shift, ifc.steps, ifc.state);
      else n_pass++;
    end
  endtask

  task automatic test_start_rate();
    int gap = 0, seen = 0;
    bit started = 1'b0;
    set_btns(4'b0100);
    for (int c = 0; c < 80 && seen < 3; c++) begin
      @(negedge clk);
      if (c == 10) set_btns(4'b0000);
      if (started) gap++;
      if (ifc.state === 2'd1 && !started) begin started = 1'b1; gap = 0; end
      if (ifc.shift === 1'b1) begin
        seen++;
        n_total++;
        if (ifc.dir !== 3'd2 || ifc.state !== 2'd1 || ifc.steps !== 8'(seen) || gap != TD)
          $display("FAIL start_rate pulse %0d: dir=%0d state=%0d steps=%0d gap=%0d, expected 2/1/%0d/%0d",
                   seen, ifc.dir, ifc.state, ifc.steps, gap, seen, TD);
        else n_pass++;
        gap = 0;
      end
    end
    n_total++;
    if (seen != 3) $display("FAIL start_timeout: got %0d pulses expected 3", seen);
    else n_pass++;
  endtask

  task automatic test_reversal();
    int seen = 0;
    press_settle(4'b0001);
    n_total++;
    if (ifc.dir !== 3'd2 || ifc.dir !== 3'(m_dir))
      $display("FAIL reversal_up: dir=%0d expected 2 (model %0d)", ifc.dir, m_dir);
    else n_pass++;
    set_btns(4'b1000);
    for (int c = 0; c < 40 && seen < 2; c++) begin
      @(negedge clk);
      if (c == 10) set_btns(4'b0000);
      n_total++;
      if ({ifc.dir, ifc.shift, ifc.steps, ifc.state} !== {3'(m_dir), m_shift, 8'(m_steps), 2'(m_state)})
        $display("FAIL reversal_model: dir/shift/steps/state got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 ifc.dir, ifc.shift, ifc.steps, ifc.state, m_dir, m_shift, m_steps, m_state);
      else n_pass++;
      if (ifc.shift === 1'b1) seen++;
    end
    set_btns(4'b0000);
    n_total++;
    if (seen != 2 || ifc.dir !== 3'd3)
      $display("FAIL reversal_left: dir=%0d pulses=%0d expected 3 after 2 pulses", ifc.dir, seen);
    else n_pass++;
  endtask

  task automatic test_priority_glitch();
    bit [2:0] exp_dir;
    press_settle(4'b0001);
    press_settle(4'b0010);
    n_total++;
    if (ifc.dir !== 3'd1 || ifc.dir !== 3'(m_dir))
      $display("FAIL setup_right: dir=%0d expected 1 (model %0d)", ifc.dir, m_dir);
    else n_pass++;
    press_settle(4'b1001);
    n_total++;
    if (ifc.dir !== 3'd0 || ifc.dir !== 3'(m_dir))
      $display("FAIL priority_up_left: dir=%0d expected 0 (model %0d)", ifc.dir, m_dir);
    else n_pass++;
    set_btns(4'b0010);
    repeat (2) @(negedge clk);
    set_btns(4'b0000);
    repeat (26) @(negedge clk);
`ifdef SNAKE_DIR_DEBOUNCE_EN
    exp_dir = 3'd0;
`else
    exp_dir = 3'd1;
`endif
    n_total++;
    if (ifc.dir !== exp_dir || ifc.dir !== 3'(m_dir))
      $display("FAIL glitch_right: dir=%0d expected %0d (model %0d)", ifc.dir, exp_dir, m_dir);
    else n_pass++;
`ifdef SNAKE_DIR_DEBOUNCE_EN
    press_settle(4'b1010);
    exp_dir = 3'd1;
`else
    press_settle(4'b0101);
    exp_dir = 3'd0;
`endif
    n_total++;
    if (ifc.dir !== exp_dir || ifc.dir !== 3'(m_dir))
      $display("FAIL priority_pair: dir=%0d expected %0d (model %0d)", ifc.dir, exp_dir, m_dir);
    else n_pass++;
  endtask

  task automatic test_pause_edge();
    int c = 0;
    int steps_before;
    while (ifc.shift !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    n_total++;
    if (ifc.shift !== 1'b1) $display("FAIL pause_sync: no shift within 20 cycles, got 0 expected 1");
    else n_pass++;
    steps_before = ifc.steps;
    repeat (TD - 1) @(negedge clk);
    ifc.pause = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_total++;
      if (ifc.shift !== 1'b0 || ifc.state !== 2'd2 || ifc.steps !== 8'(steps_before))
        $display("FAIL pause_hold k=%0d: shift/state/steps got %0d/%0d/%0d expected 0/2/%0d",
                 k, ifc.shift, ifc.state, ifc.steps, steps_before);
      else n_pass++;
    end
    ifc.pause = 1'b0;
    @(negedge clk);
    n_total++;
    if (ifc.shift !== 1'b0 || ifc.state !== 2'd1)
      $display("FAIL pause_resume: shift/state got %0d/%0d expected 0/1", ifc.shift, ifc.state);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ifc.shift !== 1'b1 || ifc.steps !== 8'(steps_before + 1))
      $display("FAIL pause_held_shift: shift/steps got %0d/%0d expected 1/%0d",
               ifc.shift, ifc.steps, steps_before + 1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit done = 1'b0;
    for (int c = 0; c < 256 * TD + 40 && !done; c++) begin
      @(negedge clk);
      n_total++;
      if ({ifc.dir, ifc.shift, ifc.steps, ifc.state} !== {3'(m_dir), m_shift, 8'(m_steps), 2'(m_state)})
        $display("FAIL wrap_model: dir/shift/steps/state got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 ifc.dir, ifc.shift, ifc.steps, ifc.state, m_dir, m_shift, m_steps, m_state);
      else n_pass++;
      if (m_shift && m_steps == 0) done = 1'b1;
    end
    n_total++;
    if (!done || ifc.steps !== 8'd0 || ifc.shift !== 1'b1)
      $display("FAIL steps_wrap: steps/shift got %0d/%0d expected 0/1", ifc.steps, ifc.shift);
    else n_pass++;
  endtask

  task automatic test_random();
    bit [3:0] b = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_total++;
      if ({ifc.dir, ifc.shift, ifc.steps, ifc.state} !== {3'(m_dir), m_shift, 8'(m_steps), 2'(m_state)})
        $display("FAIL random_model c=%0d: dir/shift/steps/state got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 c, ifc.dir, ifc.shift, ifc.steps, ifc.state, m_dir, m_shift, m_steps, m_state);
      else n_pass++;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) b[i] = ~b[i];
      set_btns(b);
      if ($urandom_range(0, 63) == 0) ifc.pause = ~ifc.pause;
    end
    set_btns(4'b0000);
    ifc.pause = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int c = 0;
    while (ifc.shift !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    n_total++;
    if (ifc.shift !== 1'b1) $display("FAIL mid_reset_sync: no shift within 40 cycles, got 0 expected 1");
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (ifc.dir !== 3'd1 || ifc.shift !== 1'b0 || ifc.steps !== 8'd0 || ifc.state !== 2'd0)
      $display("FAIL mid_reset_async: dir/shift/steps/state got %0d/%0d/%0d/%0d expected 1/0/0/0",
               ifc.dir, ifc.shift, ifc.steps, ifc.state);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_total++;
      if (ifc.state !== 2'd0 || ifc.steps !== 8'd0 || ifc.state !== 2'(m_state))
        $display("FAIL post_reset_idle k=%0d: state/steps got %0d/%0d expected 0/0", k, ifc.state, ifc.steps);
      else n_pass++;
    end
  endtask

  initial begin
    set_btns(4'b0000);
    ifc.pause = 1'b0;
    test_reset();
    test_start_rate();
    test_reversal();
    test_priority_glitch();
    test_pause_edge();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/snake_dir_controller.md
# snake_dir_controller

- Upstream stage of `move_register`.
- Converts four raw direction buttons and a pause level into the two signals that `move_register` consumes:
  - a 3-bit direction code, driving `load`;
  - a one-cycle `shift` step strobe issued at a fixed game rate.
- Enforces the snake rules at the input: no 180° reversal, one committed direction per step, no motion before the first press.

## Interface

Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per step; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 500_000: stable-high cycles required to accept a press; legal range ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  raw, asynchronous button levels.
- `pause`  in  1  level; high freezes stepping.
- `dir`  out  3  committed direction to `move_register.load`: 0 up, 1 right, 2 down, 3 left. Bit 2 is always 0.
- `shift`  out  1  one-cycle step strobe to `move_register.shift`.
- `steps`  out  8  count of issued `shift` pulses; wraps 255→0.
- `state`  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSED.

## Operation

- **Synchronizer:** each button passes through a 2-flop synchronizer.
- **Edge detect:** a rising edge of the accepted (debounced) level raises a one-cycle request for that direction.
- **Simultaneous requests:** priority up > right > down > left; lower-priority requests in the same cycle are dropped.
- **Pending register (`pend`):**
  - A request whose direction equals `(dir+2) mod 4` is rejected (reversal); all others overwrite `pend`.
  - The reversal check uses the committed `dir`, not `pend`. Therefore up→left→down within one step ends as `pend=down` only if `dir` is not up.
- **FSM:**
  - IDLE: no stepping. The first accepted request (reversal check skipped) sets `pend`, clears the tick counter and goes to RUN.
  - RUN: the tick counter increments every cycle. At `TICK_DIV-1` it wraps to 0, and on the next cycle `dir<=pend`, `shift=1`, `steps<=steps+1`. `pause=1` goes to PAUSED.
  - PAUSED: the counter holds its value and no `shift` is issued. Requests are still accepted into `pend`. `pause=0` returns to RUN, resuming the count from the held value.
- **Outputs:** `dir` and `shift` are registered and change on the same edge, so `move_register` samples the new direction with its shift.

## Timing

- **Reset values:** `dir=1` (right), `pend=1`, `shift=0`, `steps=0`, `state=IDLE`, tick counter 0, synchronizers and debouncers cleared.
- **Button latency:** button high to request = 2 sync cycles + `DEBOUNCE_CYCLES`.
- **Step period:**
  - In RUN, `shift` pulses exactly every `TICK_DIV` cycles.
  - The first pulse comes `TICK_DIV` cycles after the IDLE→RUN edge.
  - `shift` is never high for two consecutive cycles.
- **Same-cycle events:**
  - A request arriving in the same cycle as the terminal count lands in `pend` but commits at the following step.
  - `pause` rising in the same cycle as the terminal count suppresses that `shift`; the counter holds at `TICK_DIV-1` and that `shift` is issued one cycle after resume.
- **Held buttons:** a button held continuously produces one request only.
- **Mid-operation reset:** reset asserted at any time forces all reset values immediately. After release the block starts in IDLE.

## Configuration

- **Macro `SNAKE_DIR_DEBOUNCE_EN`:**
  - Defined: per-button counter; the accepted level changes only after `DEBOUNCE_CYCLES` consecutive identical synchronized samples.
  - Undefined: the synchronized level is the accepted level; `DEBOUNCE_CYCLES` is ignored and latency is 2 cycles.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use `TICK_DIV=8`, `DEBOUNCE_CYCLES=4`, with debounce enabled unless noted.

- **Reset and IDLE hold:** reset low 3 cycles, release, no buttons for 50 cycles → `dir=1`, `shift=0`, `steps=0`, `state=0` throughout.
- **Start and step rate:** press `btn_down` (held 10 cycles) from IDLE → `state=1`; `shift` pulses every 8 cycles with `dir=2`; `steps` increments 1,2,3.
- **Reversal rule:** in RUN with `dir=2`, press `btn_up` → `dir` stays 2. Then press `btn_left` → next `shift` cycle shows `dir=3`.
- **Priority and glitch filtering:**
  - `btn_up` and `btn_left` rise together from RUN with `dir=1` → `dir` becomes 0.
  - A 2-cycle `btn_right` glitch → ignored.
  - Without the macro, the same glitch is accepted.
- **Pause edge and wrap:**
  - Assert `pause` on the terminal-count cycle → no `shift`, `state=2`. Release after 20 cycles → `shift` one cycle later.
  - Run to 256 steps → `steps` wraps to 0.
- **Mid-operation reset:** assert reset during `shift=1` → outputs go to reset values asynchronously; `steps=0`.
